byte_serial_add_sequencer: RTL and testbench
============================================

Name: byte_serial_add_sequencer

Overview:
Wide-operand sequencer for the 8-bit ripple adder stage. It accepts two NUM_BYTES-wide operands and a carry-in over a valid/ready handshake. It then feeds the adder one byte slice per cycle, LSB first, chaining the adder's carry-out back in as the next carry-in, and assembles the returned sums into a wide result. The result is presented on a valid/ready output. The block sits directly around the adder: it produces the adder's x/y/carry_in and consumes its z/carry_out.

Parameters:
NUM_BYTES, 4, number of 8-bit slices per operand; legal range 2..16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operand set present.
in_ready  output  1  block can accept an operand set.
in_a  input  8*NUM_BYTES  operand A.
in_b  input  8*NUM_BYTES  operand B.
in_cin  input  1  initial carry-in.
add_x  output  8  current A slice to the adder.
add_y  output  8  current B slice to the adder.
add_cin  output  1  carry-in to the adder.
add_z  input  8  adder sum, combinational from add_x/add_y/add_cin.
add_cout  input  1  adder carry-out, combinational.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts result.
out_sum  output  8*NUM_BYTES  assembled sum.
out_cout  output  1  final carry-out.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - State = IDLE; in_ready = 1; out_valid = 0.
  - out_sum = 0; out_cout = 0.
  - add_x = 0; add_y = 0; add_cin = 0.
  - Internal slice counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1, load the A and B shift registers from in_a/in_b, load the carry register from in_cin, clear the counter, clear out_sum, and go to RUN.
  - in_ready is a pure function of state, with no combinational path from in_valid or out_ready.
- RUN:
  - in_ready = 0.
  - add_x = A_sr[7:0], add_y = B_sr[7:0], add_cin = carry register; all driven from registers.
  - Each edge:
    - Write add_z into out_sum byte[counter].
    - carry register <= add_cout.
    - Shift A_sr and B_sr right by 8.
    - counter += 1.
  - On the edge where counter = NUM_BYTES-1, also set out_cout <= add_cout and go to DONE.
- DONE:
  - out_valid = 1.
  - out_sum and out_cout are held stable until an edge with out_ready = 1, then go to IDLE.
  - No new operands are accepted in DONE.
- Adder outputs when not in RUN: add_x, add_y and add_cin are forced to 0.
- Latency: out_valid rises exactly NUM_BYTES cycles after the accepting edge. With immediate out_ready, throughput is one operation per NUM_BYTES+2 cycles.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, modulo 2^(8*NUM_BYTES+1).
- Boundary conditions:
  - in_valid while not IDLE is ignored; the upstream holds the data.
  - in_valid and out_ready both high in DONE: the result handshake completes and the input is not accepted that cycle.
  - rst asserted mid-RUN or in DONE immediately returns all outputs to reset values. The partial result is discarded and add_* go to 0.
  - Counter wrap is not possible; the counter saturates at the DONE transition.

Test Plan:
- NUM_BYTES=4, in_a=0x000000FF, in_b=0x00000001, in_cin=0, out_ready=1 -> out_valid 4 cycles after accept, out_sum=0x00000100, out_cout=0; add_cin=1 only during slice 1.
- in_a=0xFFFFFFFF, in_b=0x00000000, in_cin=1 -> out_sum=0x00000000, out_cout=1; add_cin=1 on all four RUN cycles.
- in_a=0x12345678, in_b=0x9ABCDEF0, in_cin=0, out_ready held low 5 cycles -> out_sum=0xACF13568, out_cout=0, stable throughout; in_ready=0; in_valid pulses ignored; on out_ready=1, one cycle later in_ready=1.
- rst asserted asynchronously after 2 RUN cycles of 0xFFFFFFFF+0x1 -> out_valid=0, out_sum=0, add_x=add_y=0, in_ready=1 immediately. The next transaction 0x1+0x1 returns 0x00000002 correctly.
- Back-to-back: in_valid held high with a new operand set, out_ready=1 -> accepts spaced exactly 6 cycles apart; each result matches its own operands with no carry leakage between transactions.

Source files
------------

// File: rtl/byte_serial_add_sequencer.sv
// Byte-serial wide adder sequencer: streams NUM_BYTES operand slices LSB-first
// through an external 8-bit adder, chaining carries, and assembles the result.
module byte_serial_add_sequencer #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_a,
    input  logic [8*NUM_BYTES-1:0] in_b,
    input  logic                   in_cin,
    output logic [7:0]             add_x,
    output logic [7:0]             add_y,
    output logic                   add_cin,
    input  logic [7:0]             add_z,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_sum,
    output logic                   out_cout
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_slice;

    assign last_slice = (cnt == LAST_SLICE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_x     = 8'h00;
        add_y     = 8'h00;
        add_cin   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                add_x   = a_sr[7:0];
                add_y   = b_sr[7:0];
                add_cin = carry;
                if (last_slice) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand shifters, carry chain and result assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= in_a;
                        b_sr     <= in_b;
                        carry    <= in_cin;
                        cnt      <= '0;
                        out_sum  <= '0;
                        out_cout <= 1'b0;
                    end
                end
                RUN: begin
                    out_sum[8*int'(cnt) +: 8] <= add_z;
                    carry <= add_cout;
                    a_sr  <= a_sr >> 8;
                    b_sr  <= b_sr >> 8;
                    // Counter holds at the last slice instead of wrapping.
                    if (last_slice) begin
                        out_cout <= add_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_add_sequencer.sv
// Directed bench for byte_serial_add_sequencer with a behavioural 8-bit adder
// closing the loop on add_x/add_y/add_cin -> add_z/add_cout.
module tb_byte_serial_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [7:0]   add_x;
    logic [7:0]   add_y;
    logic         add_cin;
    logic [7:0]   add_z;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_z} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};

    byte_serial_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_z    (add_z),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    // Presents one operand set from IDLE and waits (bounded) for out_valid,
    // tracing add_cin per RUN cycle and counting cycles from the accepting edge.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           output logic [NB-1:0] cin_trace, output int lat,
                           output logic [W-1:0] sum, output logic cout);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        lat       = 0;
        cin_trace = '0;
        while (!out_valid && lat < 20) begin
            if (lat < NB) cin_trace[lat] = add_cin;
            lat++;
            @(negedge clk);
        end
        sum  = out_sum;
        cout = out_cout;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end else pass_cnt++;
        total_cnt++;
        if (out_sum !== '0 || out_cout !== 1'b0) begin
            $display("FAIL reset_result: out_sum=%h out_cout=%b, required 0/0", out_sum, out_cout);
        end else pass_cnt++;
        total_cnt++;
        if (add_x !== 8'h00 || add_y !== 8'h00 || add_cin !== 1'b0) begin
            $display("FAIL reset_adder: x=%h y=%h cin=%b, required 0", add_x, add_y, add_cin);
        end else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_carry_ripple();
        logic [NB-1:0] tr; int lat; logic [W-1:0] s; logic c;
        out_ready = 1'b1;
        run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, tr, lat, s, c);
        total_cnt++;
        if (lat !== 4) $display("FAIL ripple_latency: %0d cycles, required 4", lat);
        else pass_cnt++;
        total_cnt++;
        if (s !== 32'h0000_0100 || c !== 1'b0)
            $display("FAIL ripple_sum: %h/%b, required 00000100/0", s, c);
        else pass_cnt++;
        total_cnt++;
        if (tr !== 4'b0010) $display("FAIL ripple_cin_trace: %b, required 0010", tr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL ripple_return_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_all_ones();
        logic [NB-1:0] tr; int lat; logic [W-1:0] s; logic c;
        out_ready = 1'b1;
        run_txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, tr, lat, s, c);
        total_cnt++;
        if (s !== 32'h0000_0000 || c !== 1'b1)
            $display("FAIL ones_sum: %h/%b, required 00000000/1", s, c);
        else pass_cnt++;
        total_cnt++;
        if (tr !== 4'b1111) $display("FAIL ones_cin_trace: %b, required 1111", tr);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [NB-1:0] tr; int lat; logic [W-1:0] s; logic c;
        int bad;
        out_ready = 1'b0;
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, tr, lat, s, c);
        total_cnt++;
        if (lat !== 4 || s !== 32'hACF1_3568 || c !== 1'b0)
            $display("FAIL bp_result: lat=%0d sum=%h cout=%b, required 4/acf13568/0", lat, s, c);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_a = 32'h1111_1111; in_b = 32'h2222_2222;
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'hACF1_3568 || out_cout !== 1'b0)
                bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        else pass_cnt++;
        // Both handshakes high in DONE: only the result side completes.
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_x !== 8'h00)
            $display("FAIL bp_release: in_ready=%b out_valid=%b add_x=%h, required 1/0/00", in_ready, out_valid, add_x);
        else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [NB-1:0] tr; int lat; logic [W-1:0] s; logic c;
        out_ready = 1'b1;
        @(negedge clk);
        in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (add_x !== 8'hFF || in_ready !== 1'b0)
            $display("FAIL mrst_running: add_x=%h in_ready=%b, required ff/0", add_x, in_ready);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_sum !== '0 || add_x !== 8'h00 || add_y !== 8'h00 ||
            add_cin !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mrst_clear: ov=%b sum=%h x=%h y=%h cin=%b ir=%b, required 0/0/0/0/0/1",
                     out_valid, out_sum, add_x, add_y, add_cin, in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        run_txn(32'h0000_0001, 32'h0000_0001, 1'b0, tr, lat, s, c);
        total_cnt++;
        if (lat !== 4 || s !== 32'h0000_0002 || c !== 1'b0)
            $display("FAIL mrst_next: lat=%0d sum=%h cout=%b, required 4/00000002/0", lat, s, c);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
        logic [W-1:0] vb [3] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] xs [3] = '{32'h0000_0000, 32'h0000_0003, 32'h8000_0001};
        logic         xc [3] = '{1'b1, 1'b0, 1'b0};
        logic [W-1:0] rs [3];
        logic         rc [3];
        int           acc_t [3];
        int idx, nres, cyc;
        logic take;
        for (int i = 0; i < 3; i++) begin rs[i] = 'x; rc[i] = 1'bx; acc_t[i] = -100; end
        out_ready = 1'b1;
        in_a = va[0]; in_b = vb[0]; in_cin = vc[0]; in_valid = 1'b1;
        idx = 0; nres = 0; cyc = 0;
        while (nres < 3 && cyc < 100) begin
            if (out_valid) begin rs[nres] = out_sum; rc[nres] = out_cout; nres++; end
            take = in_ready && (idx < 3);
            if (take) acc_t[idx] = cyc;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (take) begin
                idx++;
                if (idx < 3) begin in_a = va[idx]; in_b = vb[idx]; in_cin = vc[idx]; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (acc_t[1] - acc_t[0] !== 6 || acc_t[2] - acc_t[1] !== 6)
            $display("FAIL b2b_spacing: %0d,%0d cycles, required 6,6", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (rs[i] !== xs[i] || rc[i] !== xc[i])
                $display("FAIL b2b_result%0d: %h/%b, required %h/%b", i, rs[i], rc[i], xs[i], xc[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_all_ones();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
